// File: rtl/receive_engine.sv
// UART receive engine: start detect, mid-bit sampling and frame reassembly.
// Optional RX_SYNC_EN adds a two-flop synchronizer on rx.
module receive_engine #(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] baud_decode,
    input  logic              read,
    output logic [7:0]        uart_rdata,
    output logic              RxRdy,
    output logic              PERR,
    output logic              FERR,
    output logic              OVF
);

    typedef enum logic [1:0] {IDLE, START, DATA, BRK} state_t;

    localparam logic [BAUD_W-1:0] ONE = 1;

    state_t            state, state_nxt;
    logic [BAUD_W-1:0] count, baud_q;
    logic [3:0]        bit_cnt, n_last;
    logic [8:0]        shreg;
    logic [9:0]        sh_nxt;
    logic              eight_q, pen_q, ohel_q;
    logic              rx_s;
    logic              start_det, to_data, shift, complete, cnt_clr;
    logic [7:0]        frame_d;
    logic              frame_par, frame_perr;

`ifdef RX_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge clk) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], rx};
    end
    assign rx_s = rx_sync[1];
`else
    assign rx_s = rx;
`endif

    // Stop bit is the sample taken when bit_cnt reaches N-1
    assign n_last = 4'd8 + {3'd0, eight_q} + {3'd0, pen_q};
    assign sh_nxt = {rx_s, shreg};

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        to_data   = 1'b0;
        shift     = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (count == (baud_q >> 1)) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        to_data   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (count == baud_q) begin
                    shift = 1'b1;
                    if (bit_cnt == n_last) begin
                        complete  = 1'b1;
                        state_nxt = rx_s ? IDLE : BRK;
                    end
                end
            end
            BRK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cnt_clr = (state_nxt != state) || (state == IDLE) ||
                     (state == BRK) || shift;

    // Frame sits left-justified in sh_nxt with the stop bit at [9]
    always_comb begin
        frame_d   = 8'h00;
        frame_par = 1'b0;
        unique case ({eight_q, pen_q})
            2'b00: frame_d = {1'b0, sh_nxt[8:2]};
            2'b10: frame_d = sh_nxt[8:1];
            2'b01: begin
                frame_d   = {1'b0, sh_nxt[7:1]};
                frame_par = sh_nxt[8];
            end
            2'b11: begin
                frame_d   = sh_nxt[7:0];
                frame_par = sh_nxt[8];
            end
        endcase
        frame_perr = pen_q & (frame_par != (^frame_d ^ ohel_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            bit_cnt <= 4'd0;
            shreg   <= 9'd0;
            baud_q  <= '0;
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= cnt_clr ? '0 : count + ONE;
            if (start_det) begin
                baud_q  <= baud_decode;
                eight_q <= eight;
                pen_q   <= pen;
                ohel_q  <= ohel;
            end
            if (to_data)    bit_cnt <= 4'd1;
            else if (shift) bit_cnt <= bit_cnt + 4'd1;
            if (shift) shreg <= sh_nxt[9:1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_rdata <= 8'h00;
            RxRdy      <= 1'b0;
            PERR       <= 1'b0;
            FERR       <= 1'b0;
            OVF        <= 1'b0;
        end else if (complete) begin
            uart_rdata <= frame_d;
            PERR       <= frame_perr;
            FERR       <= ~rx_s;
            RxRdy      <= 1'b1;
            OVF        <= ~read & (OVF | RxRdy);
        end else if (read && RxRdy) begin
            RxRdy <= 1'b0;
            PERR  <= 1'b0;
            FERR  <= 1'b0;
            OVF   <= 1'b0;
        end
    end

endmodule
